tow_game: RTL
=============

# tow_game

Tug-of-war game controller directly downstream of the 256:1 clock-enable divider. Consumes its one-cycle `slowenable` strobe to debounce the two player buttons. Converts each debounced press into a one-step pull of a one-hot LED "rope" marker. Declares the winner when the marker is pulled past either end.

## Interface
Parameters:
- `NLED`, 7: number of rope LEDs; odd, ≥3; centre index is `(NLED-1)/2`.
- `DEB_TICKS`, 3: consecutive equal samples, taken on `slowenable` strobes, required to change a debounced button level; 1..15.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `slowenable`  in  1  one-`clk`-wide strobe, once per 256 clocks, from the divider.
- `pbl`  in  1  left player button, raw, asynchronous, active-high.
- `pbr`  in  1  right player button, raw, asynchronous, active-high.
- `led`  out  `NLED`  one-hot rope marker; bit `NLED-1` is the left end.
- `winl`  out  1  left player has won; level.
- `winr`  out  1  right player has won; level.
- `busy`  out  1  high in PLAY state.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer.
- The debouncer samples only in cycles with `slowenable`=1. It keeps a counter of consecutive samples that differ from the current debounced level. When the count reaches `DEB_TICKS`, the level flips and the counter clears. An agreeing sample clears the counter.
- A press event is a one-clock pulse on a 0→1 debounced transition. Events occur only in `slowenable` cycles.
- Position register `pos` has range 0..NLED-1. `led` = `1 << pos`.
- FSM states: PLAY, WINL, WINR.
  - PLAY, left event only: if `pos`=NLED-1, go to WINL; otherwise `pos`+1.
  - PLAY, right event only: if `pos`=0, go to WINR; otherwise `pos`-1.
  - PLAY, both events in the same cycle: no move; they cancel.
  - WINL/WINR: `pos` frozen. `led` shows `{NLED{1'b1}}` with left-half bits or right-half bits lit, as follows:
    - WINL: bits `NLED-1` down to centre.
    - WINR: bits centre down to 0.
  - WINL/WINR: all press events are ignored.
  - Restart from WINL/WINR: both debounced levels high at the same time on a `slowenable` cycle → PLAY with `pos`=centre.
- `winl`=1 only in WINL. `winr`=1 only in WINR. `busy`=1 only in PLAY.

## Timing
- Reset values:
  - state PLAY; `pos`=centre, so `led`=`1<<centre`; `winl`=`winr`=0; `busy`=1.
  - Synchronizers, debounced levels and debounce counters all 0.
- `rst` overrides everything in any cycle, including mid-debounce and in WIN states.
- Latency, synchronizer: a raw change is visible at the debouncer input 2 clocks later.
- Latency, debounce: the level flips on the `DEB_TICKS`-th consecutive differing strobe.
- Latency, outputs: `pos`/state update on the clock edge ending the event cycle. Outputs are registered and visible the next cycle.
- At most one move per `slowenable` strobe. There is no movement between strobes.
- `slowenable` held high continuously is legal: the debounce then runs every clock.
- A button held high gives one event only. A new event requires a debounced release and a re-press.

## Structure
- Shared package `tow_pkg`:
  - state encoding: PLAY=2'd0, WINL=2'd1, WINR=2'd2.
  - `NLED`/`DEB_TICKS` defaults.
  - `CTR_W` = 4.
- One sub-module, `btn_debounce`, instanced twice.
  - Contents: synchronizer, debounce counter and rising-edge pulse.
  - Ports: `clk`, `rst`, `slowenable`, `raw`, `level`, `press`.
- Top: FSM and `pos` register. `led` decode is combinational from registered state/`pos`.

## Test plan
- Reset: assert `rst` for 2 clocks → `led`=7'b0001000, `winl`=`winr`=0, `busy`=1.
- Debounce: pulse `pbl` high for 2 strobes, then low (`DEB_TICKS`=3) → no move. Hold high for 3 strobes → `led`=7'b0010000 exactly one clock after the 3rd strobe. Keep holding for 10 more strobes → still 7'b0010000.
- Left win: 4 clean left presses from reset → `led` 0010000, 0100000, 1000000, then WINL, `winl`=1, `led`=7'b1111000, `busy`=0. Further presses → no change.
- Right win and end clamp: 4 clean right presses from reset → WINR, `winr`=1, `led`=7'b0001111.
- Simultaneous: from `pos`=3, both buttons debounce-rise on the same strobe → `led` stays 7'b0001000.
- Restart and reset mid-operation: in WINL, hold both buttons 3 strobes → PLAY, `led`=7'b0001000. Then assert `rst` in the middle of a 2nd-strobe debounce of `pbr` → counter cleared; a following 2 strobes of `pbr` high give no move.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war game controller.
//   state_t        : FSM state encoding (PLAY / WINL / WINR)
//   NLED_DEF       : default number of rope LEDs
//   DEB_TICKS_DEF  : default consecutive-strobe count for a debounced level change
//   CTR_W          : width of the debounce counter
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WINL = 2'd1,
    WINR = 2'd2
  } state_t;

  localparam int NLED_DEF      = 7;
  localparam int DEB_TICKS_DEF = 3;
  localparam int CTR_W         = 4;

endpackage : tow_pkg

// File: rtl/tow_game_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, strobe-sampled debouncer and
// rising-edge press pulse.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   slowenable  : one-clock sampling strobe
//   raw         : asynchronous raw button
//   level       : debounced (registered) button level
//   press       : one-clock pulse in the strobe cycle where level rises 0->1
module btn_debounce
  import tow_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic slowenable,
  input  logic raw,
  output logic level,
  output logic press
);

  logic [1:0]       sync_q;
  logic [CTR_W-1:0] cnt_q;
  logic             differ;
  logic             flip;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the 2-FF chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], raw};
  end

  assign differ = (sync_q[1] != level);
  // Flip happens on the DEB_TICKS-th consecutive differing sample.
  assign flip   = slowenable && differ && (cnt_q == CTR_W'(DEB_TICKS - 1));
  // Press is decoded from the flip itself so the move lands on the same edge
  // that updates the debounced level.
  assign press  = flip && !level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt_q <= '0;
    end else if (slowenable) begin
      if (flip) begin
        level <= ~level;
        cnt_q <= '0;
      end else if (differ) begin
        cnt_q <= cnt_q + CTR_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule : btn_debounce

// File: rtl/tow_game.sv
// Tug-of-war game controller. Two debounced buttons pull a one-hot LED
// marker; pulling past an end declares that player the winner.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   slowenable  : one-clock strobe from the clock-enable divider
//   pbl, pbr    : raw left / right player buttons (active-high)
//   led[NLED]   : rope marker (bit NLED-1 = left end); half-bar on a win
//   winl, winr  : winner flags (levels)
//   busy        : high while the game is in play
module tow_game
  import tow_pkg::*;
#(
  parameter int NLED      = NLED_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowenable,
  input  logic            pbl,
  input  logic            pbr,
  output logic [NLED-1:0] led,
  output logic            winl,
  output logic            winr,
  output logic            busy
);

  localparam int          POS_W  = $clog2(NLED);
  localparam int          CENTRE = (NLED - 1) / 2;
  localparam logic [POS_W-1:0] POS_CENTRE = POS_W'(CENTRE);
  localparam logic [POS_W-1:0] POS_LEFT   = POS_W'(NLED - 1);

  logic level_l, level_r;
  logic press_l, press_r;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_l (
    .clk        (clk),
    .rst        (rst),
    .slowenable (slowenable),
    .raw        (pbl),
    .level      (level_l),
    .press      (press_l)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_r (
    .clk        (clk),
    .rst        (rst),
    .slowenable (slowenable),
    .raw        (pbr),
    .level      (level_r),
    .press      (press_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PLAY;
      pos_q   <= POS_CENTRE;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    unique case (state_q)
      PLAY: begin
        // Simultaneous presses cancel; only a lone press moves the marker.
        if (press_l && !press_r) begin
          if (pos_q == POS_LEFT) state_d = WINL;
          else                   pos_d   = pos_q + POS_W'(1);
        end else if (press_r && !press_l) begin
          if (pos_q == '0) state_d = WINR;
          else             pos_d   = pos_q - POS_W'(1);
        end
      end
      WINL, WINR: begin
        if (slowenable && level_l && level_r) begin
          state_d = PLAY;
          pos_d   = POS_CENTRE;
        end
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_CENTRE;
      end
    endcase
  end

  always_comb begin
    led = '0;
    unique case (state_q)
      WINL:    for (int i = 0; i < NLED; i++) led[i] = (i >= CENTRE);
      WINR:    for (int i = 0; i < NLED; i++) led[i] = (i <= CENTRE);
      default: led = NLED'(1) << pos_q;
    endcase
  end

  assign winl = (state_q == WINL);
  assign winr = (state_q == WINR);
  assign busy = (state_q == PLAY);

endmodule : tow_game
